// File: rtl/pause_timer_arbiter.sv
// Round-robin share of one prescaled pause timer: grant at t+1, done pulse (sc+1)*(len+1) clocks later.
// No backpressure; a requester aborts by dropping req, and other requests wait in place until IDLE.
module pause_timer_arbiter #(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 16,
  parameter int PRE_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       sclr,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*WIDTH-1:0]     length,
  input  logic [PRE_WIDTH-1:0]       scale,
  output logic [N_REQ-1:0]           gnt,
  output logic [N_REQ-1:0]           done,
  output logic                       busy,
  output logic [$clog2(N_REQ)-1:0]   active_id
);

  localparam int IW = $clog2(N_REQ);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t               r_state, w_state_nxt;
  logic [N_REQ-1:0]     r_gnt, w_gnt_nxt;
  logic [IW-1:0]        r_active_id, w_active_id_nxt;
  logic [IW-1:0]        r_ptr, w_ptr_nxt;
  logic [IW-1:0]        w_winner, w_id_inc;
  logic                 w_any;
  logic [WIDTH-1:0]     r_len, w_len_nxt, r_cnt, w_cnt_nxt;
  logic [PRE_WIDTH-1:0] r_sc, w_sc_nxt, r_pre, w_pre_nxt;
  logic                 w_tick;

  // First requester at or above the pointer, wrapping past N_REQ-1.
  always_comb begin : arb
    int idx;
    idx      = 0;
    w_winner = r_ptr;
    w_any    = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(r_ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!w_any && req[idx]) begin
        w_any    = 1'b1;
        w_winner = IW'(idx);
      end
    end
  end

  assign w_id_inc = (r_active_id == IW'(N_REQ - 1)) ? '0 : r_active_id + IW'(1);
  assign w_tick   = (r_pre == r_sc);

  always_comb begin
    w_state_nxt     = r_state;
    w_gnt_nxt       = r_gnt;
    w_active_id_nxt = r_active_id;
    w_ptr_nxt       = r_ptr;
    w_len_nxt       = r_len;
    w_sc_nxt        = r_sc;
    w_pre_nxt       = r_pre;
    w_cnt_nxt       = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_state_nxt     = S_RUN;
          w_gnt_nxt       = N_REQ'(1) << w_winner;
          w_active_id_nxt = w_winner;
          w_len_nxt       = length[int'(w_winner)*WIDTH +: WIDTH];
          w_sc_nxt        = scale;
          w_pre_nxt       = '0;
          w_cnt_nxt       = '0;
        end
      end
      S_RUN: begin
        if (!req[r_active_id]) begin
          w_state_nxt = S_IDLE;
          w_gnt_nxt   = '0;
          w_ptr_nxt   = w_id_inc;
        end else begin
          // Compare before increment so terminal values never wrap.
          w_pre_nxt = w_tick ? '0 : r_pre + PRE_WIDTH'(1);
          if (w_tick) begin
            if (r_cnt == r_len) begin
              w_state_nxt = S_DONE;
              w_gnt_nxt   = '0;
            end else begin
              w_cnt_nxt = r_cnt + WIDTH'(1);
            end
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_gnt_nxt   = '0;
        w_ptr_nxt   = w_id_inc;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (sclr) begin
      r_state     <= S_IDLE;
      r_gnt       <= '0;
      r_active_id <= '0;
      r_ptr       <= '0;
      r_len       <= '0;
      r_sc        <= '0;
      r_pre       <= '0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_gnt       <= w_gnt_nxt;
      r_active_id <= w_active_id_nxt;
      r_ptr       <= w_ptr_nxt;
      r_len       <= w_len_nxt;
      r_sc        <= w_sc_nxt;
      r_pre       <= w_pre_nxt;
      r_cnt       <= w_cnt_nxt;
    end
  end

  assign gnt       = r_gnt;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE) ? (N_REQ'(1) << r_active_id) : '0;
  assign active_id = r_active_id;

endmodule

// File: tb/tb_pause_timer_arbiter.sv
// Directed bench for pause_timer_arbiter: single, minimum, round-robin, abort, latching and reset-mid-run cases.
module tb_pause_timer_arbiter;
  localparam int N  = 4;
  localparam int W  = 16;
  localparam int PW = 16;

  logic           clk = 1'b0;
  logic           sclr;
  logic [N-1:0]   req;
  logic [N*W-1:0] length;
  logic [PW-1:0]  scale;
  logic [N-1:0]   gnt;
  logic [N-1:0]   done;
  logic           busy;
  logic [1:0]     active_id;

  int    n_assert = 0;
  int    n_fail   = 0;
  string phase    = "init";

  always #5 clk = ~clk;

  pause_timer_arbiter #(.N_REQ(N), .WIDTH(W), .PRE_WIDTH(PW)) dut (
    .clk(clk), .sclr(sclr), .req(req), .length(length), .scale(scale),
    .gnt(gnt), .done(done), .busy(busy), .active_id(active_id)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
    end
  endtask

  task automatic chk_idle();
    chk("idle_gnt",  32'(gnt),  32'd0);
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  // Called in the cycle before the expected grant; ends in the done cycle.
  task automatic pause(input int id, input int cycles, input bit idle_first,
                       input bit drop, input bit change);
    logic [N-1:0] oh;
    oh = N'(1) << id;
    if (idle_first) begin
      tick();
      chk_idle();
    end
    for (int k = 1; k <= cycles + 1; k++) begin
      tick();
      chk("gnt",  32'(gnt),  (k <= cycles)     ? 32'(oh) : 32'd0);
      chk("done", 32'(done), (k == cycles + 1) ? 32'(oh) : 32'd0);
      chk("busy", 32'(busy), 32'd1);
      if (k == 1 || k == cycles + 1) chk("active_id", 32'(active_id), 32'(id));
      if (change && k == 2) begin
        scale  = scale + 16'd5;
        length = {N{16'd7}};
      end
      if (drop && k == cycles + 1) req = '0;
    end
  endtask

  initial begin
    sclr   = 1'b1;
    req    = '0;
    length = '0;
    scale  = '0;
    tick();
    tick();
    phase = "reset";
    chk("gnt",       32'(gnt),       32'd0);
    chk("done",      32'(done),      32'd0);
    chk("busy",      32'(busy),      32'd0);
    chk("active_id", 32'(active_id), 32'd0);
    sclr = 1'b0;
    tick();
    tick();
    chk_idle();

    // 4 * 5 = 20 RUN cycles
    phase = "single";
    scale = 16'd3;
    length[0*W +: W] = 16'd4;
    req = 4'b0001;
    pause(0, 20, 1'b0, 1'b1, 1'b0);
    tick();
    chk_idle();

    // Pointer is 1 here; request 2 wins, one-cycle RUN.
    phase = "minimum";
    scale = 16'd0;
    length[2*W +: W] = 16'd0;
    req = 4'b0100;
    pause(2, 1, 1'b0, 1'b1, 1'b0);
    tick();
    chk_idle();

    phase = "rr_reset";
    sclr = 1'b1;
    tick();
    sclr = 1'b0;
    chk("gnt",       32'(gnt),       32'd0);
    chk("active_id", 32'(active_id), 32'd0);

    phase = "round_robin";
    scale  = 16'd0;
    length = {N{16'd1}};
    req    = 4'b1111;
    pause(0, 2, 1'b0, 1'b0, 1'b0);
    pause(1, 2, 1'b1, 1'b0, 1'b0);
    pause(2, 2, 1'b1, 1'b0, 1'b0);
    pause(3, 2, 1'b1, 1'b0, 1'b0);
    pause(0, 2, 1'b1, 1'b1, 1'b0);
    tick();
    chk_idle();

    // Pointer is 1: request 1 wins, aborts after 25 RUN cycles, then 3 (pointer 2) wins.
    phase = "abort";
    scale = 16'd9;
    length[1*W +: W] = 16'd100;
    length[3*W +: W] = 16'd0;
    req = 4'b1010;
    for (int k = 1; k <= 25; k++) begin
      tick();
      chk("run_gnt",  32'(gnt),  32'h2);
      chk("run_done", 32'(done), 32'd0);
      if (k == 25) req[1] = 1'b0;
    end
    tick();
    chk_idle();
    pause(3, 10, 1'b0, 1'b1, 1'b0);
    tick();
    chk_idle();

    // Latched scale=1, len=2 -> 6 cycles despite mid-run changes.
    phase = "latch";
    scale = 16'd1;
    length[0*W +: W] = 16'd2;
    req = 4'b0001;
    pause(0, 6, 1'b0, 1'b1, 1'b1);
    tick();
    chk_idle();

    // Pointer is 1 so requester 1 wins first; after sclr the pointer is 0 so requester 0 wins.
    phase = "sclr_mid_run";
    scale = 16'd0;
    req   = 4'b0011;
    tick();
    chk("first_gnt", 32'(gnt), 32'h2);
    tick();
    tick();
    chk("run_gnt", 32'(gnt), 32'h2);
    sclr = 1'b1;
    tick();
    chk("gnt",       32'(gnt),       32'd0);
    chk("done",      32'(done),      32'd0);
    chk("busy",      32'(busy),      32'd0);
    chk("active_id", 32'(active_id), 32'd0);
    sclr = 1'b0;
    pause(0, 8, 1'b0, 1'b1, 1'b0);
    tick();
    chk_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pause_timer_arbiter.md
Name: pause_timer_arbiter

Overview:
- Shares one prescaled pause timer (prescaler + length counter) among N_REQ requesters, e.g. the motor, generator and feedback channels of the CNC controller.
- Round-robin arbitration grants the timer to one requester at a time, runs a pause of (scale+1)*(length+1) clocks, then pulses done to that requester.
- A requester may withdraw its request mid-pause to abort.

Parameters:
N_REQ, 4, number of requesters (2..8)
WIDTH, 16, length counter width
PRE_WIDTH, 16, prescaler width

Ports:
clk  in  1  system clock
sclr  in  1  synchronous active-high reset
req  in  N_REQ  per-requester pause request, level, held until done or abort
length  in  N_REQ*WIDTH  per-requester pause length; slice i = length[i*WIDTH +: WIDTH]
scale  in  PRE_WIDTH  common prescaler terminal value; tick period = scale+1 clocks
gnt  out  N_REQ  one-hot grant, registered
done  out  N_REQ  one-clock completion pulse to granted requester
busy  out  1  high in RUN or DONE
active_id  out  $clog2(N_REQ)  index of current or last grantee

Behaviour:
- One clock, reset synchronous and active-high on sclr; all state updates on posedge clk.
- Reset values:
  - state=IDLE, gnt=0, done=0, busy=0, active_id=0
  - rr pointer=0, prescaler=0, cnt=0
  - sclr overrides every other event, including mid-RUN; no done is issued.
- State machine:
  - IDLE: if req!=0, pick the first set bit scanning from the rr pointer upward, wrapping. Next cycle: state=RUN, gnt one-hot at the winner, active_id=winner. Latch len=length[winner] and sc=scale; prescaler=0, cnt=0.
  - RUN, each cycle:
    - If req[active_id]==0: abort. Next state=IDLE, gnt=0, no done, rr pointer=active_id+1 mod N_REQ.
    - Otherwise tick = (prescaler==sc). On tick, prescaler=0, else prescaler+1.
    - On tick with cnt==len: next state=DONE. On tick otherwise: cnt+1.
  - DONE (one cycle): done[active_id]=1, gnt=0, busy=1, rr pointer=active_id+1 mod N_REQ. Next state=IDLE.
- Timing: RUN lasts exactly (sc+1)*(len+1) cycles.
- Latency:
  - req rising while IDLE at cycle t gives gnt at t+1.
  - done is at t+1+(sc+1)*(len+1).
  - The earliest next grant is 2 cycles after the done cycle (IDLE cycle, then grant).
- len and sc are latched at grant; later changes to length or scale take effect only at the next grant.
- Boundary cases:
  - scale=0, length=0: RUN lasts 1 cycle.
  - Maximum values: prescaler and cnt compare before incrementing, so they never wrap.
- Fairness: after done or abort the pointer moves past the grantee. A requester holding req across done is re-granted only if no other request is pending.
- Simultaneous requests in IDLE: the lowest index at or above the pointer wins; requests not granted stay pending with no loss.
- A req rising during RUN or DONE is ignored until IDLE.
- done and gnt are never high in the same cycle. gnt is at most one-hot.

Test Plan:
- Single request: scale=3, length[0]=4, req[0] rises at cycle 10 -> gnt[0] cycles 11..30 (20 cycles), done[0] at cycle 31 only, busy 11..31.
- Minimum pause: scale=0, length[2]=0, req[2] -> gnt[2] for exactly 1 cycle, done[2] the next cycle.
- Round-robin: req=4'b1111 held, scale=0, all lengths=1.
  - Grants run 0,1,2,3,0 in order; each gnt lasts 2 cycles; each done is followed by one IDLE cycle.
  - Requests are re-granted after each done.
- Abort: scale=9, length[1]=100, drop req[1] at 25 cycles into RUN -> gnt[1] falls next cycle, no done[1]. A pending req[3] is granted 2 cycles later (pointer=2, scanning 2->3).
- Latching: change length[0] and scale mid-RUN -> pause duration still matches the values at grant.
- Reset mid-RUN: assert sclr for 1 cycle during RUN -> gnt, busy and done at 0 the next cycle, pointer=0. With req[0] still high, the grant returns 1 cycle after sclr deasserts.
